// File: rtl/freq_tracker.sv
// Dominant-frequency tracker: keeps a sliding window of recent frequency-bin results,
// finds the most frequent bin with a 16-cycle scan and hands it to a host via valid/ready.
module freq_tracker #(
  parameter int WIN       = 8,
  parameter int STABLE_TH = 6,
  localparam int CW       = $clog2(WIN + 1),
  localparam int PW       = $clog2(WIN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          done_i,
  input  logic [3:0]    freq_i,
  input  logic          clr_i,
  output logic          res_valid_o,
  input  logic          res_ready_i,
  output logic [3:0]    dom_freq_o,
  output logic [CW-1:0] dom_count_o,
  output logic [CW-1:0] fill_o,
  output logic          stable_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [3:0]    hbuf_q [WIN];
  logic [3:0]    hbuf_d [WIN];
  logic [CW-1:0] hist_q [16];
  logic [CW-1:0] hist_d [16];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] fill_q, fill_d;

  logic [1:0]    state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [CW-1:0] best_cnt_q, best_cnt_d;
  logic [3:0]    best_idx_q, best_idx_d;
  logic          pending_q, pending_d;
  logic          res_valid_q, res_valid_d;
  logic [3:0]    dom_freq_q, dom_freq_d;
  logic [CW-1:0] dom_count_q, dom_count_d;
  logic          stable_q, stable_d;

  logic [3:0]    oldest;
  logic          take;
  logic [CW-1:0] cand_cnt;
  logic [3:0]    cand_idx;

  assign oldest = hbuf_q[wptr_q];

  // Window and histogram update; runs on every done regardless of FSM state.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    hbuf_d = hbuf_q;
    hist_d = hist_q;
    wptr_d = wptr_q;
    fill_d = fill_q;
    if (clr_i) begin
      for (int i = 0; i < WIN; i++) hbuf_d[i] = '0;
      for (int i = 0; i < 16; i++) hist_d[i] = '0;
      wptr_d = '0;
      fill_d = '0;
    end else if (done_i) begin
      if (fill_q < CW'(WIN)) begin
        hist_d[freq_i] = hist_q[freq_i] + CW'(1);
        fill_d         = fill_q + CW'(1);
      end else if (oldest != freq_i) begin
        hist_d[oldest] = hist_q[oldest] - CW'(1);
        hist_d[freq_i] = hist_q[freq_i] + CW'(1);
      end
      hbuf_d[wptr_q] = freq_i;
      wptr_d         = wptr_q + PW'(1);
    end
  end

  // Strict greater-than keeps the lower index on ties.
  assign take     = hist_q[idx_q] > best_cnt_q;
  assign cand_cnt = take ? hist_q[idx_q] : best_cnt_q;
  assign cand_idx = take ? idx_q : best_idx_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    best_cnt_d  = best_cnt_q;
    best_idx_d  = best_idx_q;
    pending_d   = pending_q;
    res_valid_d = res_valid_q;
    dom_freq_d  = dom_freq_q;
    dom_count_d = dom_count_q;
    stable_d    = stable_q;
    case (state_q)
      IDLE: begin
        if (done_i) begin
          state_d    = SCAN;
          idx_d      = '0;
          best_cnt_d = '0;
          best_idx_d = '0;
        end
      end
      SCAN: begin
        if (done_i) begin
          idx_d      = '0;
          best_cnt_d = '0;
          best_idx_d = '0;
        end else begin
          best_cnt_d = cand_cnt;
          best_idx_d = cand_idx;
          if (idx_q == 4'd15) begin
            state_d     = HOLD;
            res_valid_d = 1'b1;
            dom_freq_d  = cand_idx;
            dom_count_d = cand_cnt;
            stable_d    = (fill_q == CW'(WIN)) && (cand_cnt >= CW'(STABLE_TH));
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      HOLD: begin
        if (res_valid_q && res_ready_i) begin
          res_valid_d = 1'b0;
          pending_d   = 1'b0;
          if (pending_q || done_i) begin
            state_d    = SCAN;
            idx_d      = '0;
            best_cnt_d = '0;
            best_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (done_i) begin
          pending_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; next state comes from the _d logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: history and histogram are reset explicitly because the window must start empty.
      for (int i = 0; i < WIN; i++) hbuf_q[i] <= '0;
      for (int i = 0; i < 16; i++) hist_q[i] <= '0;
      wptr_q      <= '0;
      fill_q      <= '0;
      state_q     <= IDLE;
      idx_q       <= '0;
      best_cnt_q  <= '0;
      best_idx_q  <= '0;
      pending_q   <= 1'b0;
      res_valid_q <= 1'b0;
      dom_freq_q  <= '0;
      dom_count_q <= '0;
      stable_q    <= 1'b0;
    end else begin
      hbuf_q      <= hbuf_d;
      hist_q      <= hist_d;
      wptr_q      <= wptr_d;
      fill_q      <= fill_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      best_cnt_q  <= best_cnt_d;
      best_idx_q  <= best_idx_d;
      pending_q   <= pending_d;
      res_valid_q <= res_valid_d;
      dom_freq_q  <= dom_freq_d;
      dom_count_q <= dom_count_d;
      stable_q    <= stable_d;
    end
  end

  assign res_valid_o = res_valid_q;
  assign dom_freq_o  = dom_freq_q;
  assign dom_count_o = dom_count_q;
  assign fill_o      = fill_q;
  assign stable_o    = stable_q;

endmodule

// File: tb/tb_freq_tracker.sv
// Bench for freq_tracker: directed scenarios plus random traffic, results checked by a
// scoreboard against a window model that counts occurrences directly.
module tb_freq_tracker;
  localparam int WIN       = 8;
  localparam int STABLE_TH = 6;
  localparam int CW        = $clog2(WIN + 1);

  typedef struct {
    logic [3:0]    f;
    logic [CW-1:0] c;
    logic [CW-1:0] fill;
    logic          s;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst, done, clr, res_ready;
  logic [3:0]    freq;
  logic          res_valid, stable;
  logic [3:0]    dom_freq;
  logic [CW-1:0] dom_count, fill;

  int         vectors = 0;
  int         miscompares = 0;
  logic [3:0] win_q[$];
  exp_t       exp_q[$];

  freq_tracker #(.WIN(WIN), .STABLE_TH(STABLE_TH)) dut (
    .clk(clk), .rst(rst), .done_i(done), .freq_i(freq), .clr_i(clr),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .dom_freq_o(dom_freq),
    .dom_count_o(dom_count), .fill_o(fill), .stable_o(stable)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_push(input logic [3:0] f);
    win_q.push_back(f);
    if (win_q.size() > WIN) void'(win_q.pop_front());
  endtask

  function automatic exp_t model_result();
    int   cnt[16];
    int   best, bi;
    exp_t r;
    for (int b = 0; b < 16; b++) cnt[b] = 0;
    foreach (win_q[i]) cnt[win_q[i]]++;
    best = 0;
    bi   = 0;
    for (int b = 0; b < 16; b++) if (cnt[b] > best) begin best = cnt[b]; bi = b; end
    r.f    = 4'(bi);
    r.c    = CW'(best);
    r.fill = CW'(win_q.size());
    r.s    = (win_q.size() == WIN) && (best >= STABLE_TH);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [3:0] f);
    done = 1'b1;
    freq = f;
    tick();
    done = 1'b0;
    model_push(f);
  endtask

  task automatic send_expect(input logic [3:0] f);
    send(f);
    exp_q.push_back(model_result());
  endtask

  // Called right after the done edge: valid must rise exactly 17 cycles after done.
  task automatic check_latency(input string nm);
    ticks(15);
    check({nm, "_valid_early"}, int'(res_valid), 0);
    tick();
    check({nm, "_valid_at_17"}, int'(res_valid), 1);
  endtask

  task automatic check_dom(input string nm, input int f, input int c, input int s);
    check({nm, "_dom_freq"}, int'(dom_freq), f);
    check({nm, "_dom_count"}, int'(dom_count), c);
    check({nm, "_stable"}, int'(stable), s);
  endtask

  task automatic check_quiet(input string nm, input int n);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (res_valid) seen++;
    end
    check({nm, "_valid_cycles"}, seen, 0);
  endtask

  // Monitor: pops one expectation per handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL spurious_result: got dom_freq=%0d dom_count=%0d, expected no result",
                   dom_freq, dom_count);
        end else begin
          e = exp_q.pop_front();
          check("sb_dom_freq", int'(dom_freq), int'(e.f));
          check("sb_dom_count", int'(dom_count), int'(e.c));
          check("sb_fill", int'(fill), int'(e.fill));
          check("sb_stable", int'(stable), int'(e.s));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] f;
    rst = 1'b1; done = 1'b0; clr = 1'b0; res_ready = 1'b0; freq = '0;
    tick();
    done = 1'b1; freq = 4'd5; res_ready = 1'b1;
    tick();
    done = 1'b0; res_ready = 1'b0; rst = 1'b0;
    check("rst_valid", int'(res_valid), 0);
    check("rst_fill", int'(fill), 0);
    check_dom("rst", 0, 0, 0);
    check_quiet("rst_idle", 20);

    res_ready = 1'b1;
    send_expect(4'd5);
    check_latency("single");
    tick();
    check("single_valid_one_cycle", int'(res_valid), 0);
    check_dom("single", 5, 1, 0);
    check("single_fill", int'(fill), 1);
    ticks(2);

    for (int i = 0; i < 8; i++) begin
      send_expect(4'd3);
      ticks(19);
    end
    check_dom("all3", 3, 8, 1);
    check("all3_fill", int'(fill), 8);

    for (int i = 1; i <= 8; i++) begin
      send_expect(4'd9);
      ticks(19);
      if (i == 4) check_dom("tie44", 3, 4, 0);
      if (i == 5) check_dom("nine5", 9, 5, 0);
      if (i == 8) check_dom("nine8", 9, 8, 1);
    end

    res_ready = 1'b0;
    send_expect(4'd9);
    ticks(19);
    check("bp_valid_held", int'(res_valid), 1);
    send(4'd7);
    ticks(3);
    send(4'd7);
    ticks(20);
    check("bp_valid_still", int'(res_valid), 1);
    check_dom("bp_frozen", 9, 8, 1);
    exp_q.push_back(model_result());
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("bp_valid_drop", int'(res_valid), 0);
    check_latency("bp_rescan");
    check_dom("bp_rescan", 9, 6, 1);
    res_ready = 1'b1;
    check_quiet("bp_single_rescan", 20);

    send(4'd4);
    ticks(10);
    send_expect(4'd4);
    check_latency("restart");
    ticks(3);

    send(4'd1);
    ticks(5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    win_q.delete();
    check("midrst_fill", int'(fill), 0);
    check_dom("midrst", 0, 0, 0);
    check_quiet("midrst", 20);

    send_expect(4'd6);
    ticks(19);
    clr = 1'b1; done = 1'b1; freq = 4'd11;
    tick();
    clr = 1'b0; done = 1'b0;
    win_q.delete();
    exp_q.push_back(model_result());
    check("clr_fill", int'(fill), 0);
    ticks(19);
    check_dom("clr_scan", 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      f = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
      send_expect(f);
      ticks(17 + $urandom_range(0, 5));
      if (i % 10 == 9) begin
        clr = 1'b1;
        tick();
        clr = 1'b0;
        win_q.delete();
        check("rand_clr_fill", int'(fill), 0);
      end
    end

    ticks(5);
    check("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/freq_tracker.md
Name: freq_tracker

Overview:
- Sits directly downstream of the frequency analysis system and consumes its per-frame `done`/`freq` result pulses.
- Keeps a sliding window of the last WIN detected frequency indices and finds the dominant (most frequent) index by a sequential 16-bin scan.
- Presents the result to a host through a valid/ready handshake, with a stability flag for noisy-tone rejection.

Parameters:
- WIN, 8, history window depth in results; power of 2, range 2..16.
- STABLE_TH, 6, minimum occurrence count of the dominant index for `stable`; range 1..WIN.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- done  input  1  one-cycle pulse; `freq` is valid in this cycle.
- freq  input  4  detected frequency bin index 0..15.
- clr  input  1  synchronous clear of history and histogram; leaves handshake state intact.
- res_valid  output  1  result available.
- res_ready  input  1  host accepts result when `res_valid` and `res_ready` are both high.
- dom_freq  output  4  dominant bin index.
- dom_count  output  CW  occurrences of `dom_freq` in the window; CW = clog2(WIN+1).
- fill  output  CW  number of valid entries in the window (saturates at WIN).
- stable  output  1  `fill==WIN` and `dom_count>=STABLE_TH`.

Behaviour:
- Reset (`rst`=1 at a clock edge):
  - All outputs go to 0; history, histogram, pending flag and scan index are cleared; state = IDLE.
  - `rst` overrides everything, including mid-SCAN and mid-HOLD.
- Storage:
  - Circular history buffer of WIN x 4 bits with a write pointer that wraps at WIN.
  - 16 histogram counters, each CW bits wide.
- Update path (acts on every `done`, independent of FSM state); at the edge after `done`:
  - If `fill<WIN`: `hist[freq]++`, `fill++`.
  - Else: `hist[oldest]--` and `hist[freq]++`; if `oldest==freq`, the histogram is unchanged.
  - Write `freq` to `buf[wptr]`; `wptr` increments and wraps.
  - Counters never exceed WIN and never underflow.
- `clr`:
  - Zeroes history, histogram, `fill` and `wptr` next cycle.
  - If asserted together with `done`, `clr` wins and the sample is dropped.
  - Does not change the FSM state or the outputs.
- FSM, IDLE:
  - On `done`, go to SCAN with idx=0, `best_cnt`=0, `best_idx`=0.
- FSM, SCAN (16 cycles, idx 0..15, one bin per cycle):
  - If `hist[idx] > best_cnt`, take `idx` as the new best.
  - Ties keep the lower index (strict greater-than).
  - A `done` during SCAN restarts the scan at idx=0 on the next cycle.
  - After idx=15, go to HOLD and register `dom_freq`, `dom_count`, `stable`; `res_valid`=1.
- Latency:
  - `done` at cycle T (IDLE) gives `res_valid` high at T+17, provided no further `done` arrives.
  - The scan at T+1 already sees the updated histogram.
- FSM, HOLD:
  - Outputs stay frozen while `res_valid` is high and no handshake occurs.
  - A `done` in HOLD updates the histogram and sets `pending`; multiple `done` pulses coalesce into one pending rescan.
  - On handshake: `res_valid`=0 next cycle; go to SCAN if `pending` (clearing it), else IDLE.
  - A `done` in the same cycle as the handshake counts as pending.
- Output timing:
  - `fill` is a live registered value.
  - `dom_*` and `stable` update only on entry to HOLD.
- Window state with `fill`=0:
  - Reachable after `clr`; the scan then yields `dom_freq`=0, `dom_count`=0, `stable`=0.

Test Plan:
1. Assert `rst` for 2 cycles, with `done` and `res_ready` pulsed during reset -> all outputs 0, no `res_valid` for 20 cycles.
2. `res_ready`=1; single `done` with `freq`=5 at cycle T -> `res_valid` for exactly 1 cycle at T+17; `dom_freq`=5, `dom_count`=1, `fill`=1, `stable`=0.
3. 8 `done` pulses with `freq`=3, spaced 20 cycles, each acked -> last result `dom_freq`=3, `dom_count`=8, `fill`=8, `stable`=1.
4. After scenario 3, send `freq`=9 pulses, each acked:
   - after the 4th -> 4/4 tie, `dom_freq`=3, `dom_count`=4;
   - after the 5th -> `dom_freq`=9, `dom_count`=5, `stable`=0;
   - after the 8th -> `dom_count`=8, `stable`=1.
5. Backpressure: `res_ready`=0 in HOLD; `done` with `freq`=7 twice -> outputs unchanged while held. Raise `res_ready` for 1 cycle -> exactly one rescan, whose result includes both 7s (`hist[7]`=2).
6. Mid-operation events:
   - `done` at SCAN idx=10 -> scan restarts; `res_valid` 17 cycles after the second `done`.
   - `rst` at SCAN idx=5 -> back to IDLE, `res_valid` never asserted.
   - `clr` together with `done` -> `fill`=0 and the sample is dropped.
